// File: rtl/tcs3200_color_judge_if.sv
// Signal bundle between the TCS3200 colour judge and its environment.
// The master side drives the sensor OUT pin; the slave side (the judge)
// drives the filter selects, the per-channel counts and the colour result.
interface tcs3200_color_judge_if #(
   parameter int CNT_W = 16
);
   logic             sensor_out;
   logic             s2;
   logic             s3;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] g_cnt;
   logic [CNT_W-1:0] b_cnt;
   logic             meas_done;
   logic             r_valid;
   logic             g_valid;
   logic             b_valid;

   modport master (
      output sensor_out,
      input  s2, s3, r_cnt, g_cnt, b_cnt, meas_done, r_valid, g_valid, b_valid
   );

   modport slave (
      input  sensor_out,
      output s2, s3, r_cnt, g_cnt, b_cnt, meas_done, r_valid, g_valid, b_valid
   );
endinterface

// File: rtl/tcs3200_color_judge.sv
// TCS3200 colour judge: steps the sensor filter through red, blue and green,
// counts OUT edges in a fixed window per filter, picks the dominant colour and
// only changes the r/g/b valid levels once the same verdict has been seen
// PERSIST rounds in a row.
module tcs3200_color_judge #(
   parameter int SETTLE_CYC = 5000,
   parameter int GATE_CYC   = 500000,
   parameter int CNT_W      = 16,
   parameter int MIN_CNT    = 200,
   parameter int PERSIST    = 3
) (
   input logic                  sys_clk,
   input logic                  sys_rst_n,
   tcs3200_color_judge_if.slave bus
);

   localparam int TMR_MAX = (SETTLE_CYC > GATE_CYC) ? SETTLE_CYC : GATE_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int PER_W   = $clog2(PERSIST + 1);

   localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
   localparam logic [TMR_W-1:0] GATE_LD   = TMR_W'(GATE_CYC - 1);
   localparam logic [TMR_W-1:0] TMR_ZERO  = TMR_W'(0);
   localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_CNT);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
   localparam logic [PER_W-1:0] PER_C     = PER_W'(PERSIST);

   typedef enum logic [3:0] {
      ST_SET_R  = 4'd0,
      ST_WAIT_R = 4'd1,
      ST_GATE_R = 4'd2,
      ST_SET_B  = 4'd3,
      ST_WAIT_B = 4'd4,
      ST_GATE_B = 4'd5,
      ST_SET_G  = 4'd6,
      ST_WAIT_G = 4'd7,
      ST_GATE_G = 4'd8,
      ST_JUDGE  = 4'd9
   } state_t;

   typedef enum logic [1:0] {
      COL_NONE = 2'd0,
      COL_R    = 2'd1,
      COL_G    = 2'd2,
      COL_B    = 2'd3
   } color_t;

   // Valid pattern {r,g,b} for a verdict; "none" clears all three.
   function automatic logic [2:0] color_onehot(input color_t c);
      case (c)
         COL_R:   return 3'b100;
         COL_G:   return 3'b010;
         COL_B:   return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   state_t           state_q;
   logic [TMR_W-1:0] timer_q;
   logic [CNT_W-1:0] edge_cnt_q;
   logic [CNT_W-1:0] edge_cnt_d;
   logic [CNT_W-1:0] r_cnt_q;
   logic [CNT_W-1:0] g_cnt_q;
   logic [CNT_W-1:0] b_cnt_q;
   logic             s2_q;
   logic             s3_q;
   logic             meas_done_q;
   logic [2:0]       valid_q;
   color_t           cand_q;
   color_t           cand_d;
   color_t           judge_res;
   logic [PER_W-1:0] pers_q;
   logic [PER_W-1:0] pers_d;
   logic             sync1_q;
   logic             sync2_q;
   logic             prev_q;
   logic             edge_det;

   // Two-stage synchronizer for the asynchronous OUT pin plus a delay stage for edge detection
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= bus.sensor_out;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign edge_det = sync2_q & ~prev_q;

   // Next edge count, sticking at all-ones so a flooded channel cannot wrap
   always_comb begin
      if (edge_det && (edge_cnt_q != CNT_MAX)) begin
         edge_cnt_d = edge_cnt_q + CNT_W'(1);
      end else begin
         edge_cnt_d = edge_cnt_q;
      end
   end

   // Dominant colour: strictly above both others and at least MIN_CNT; ties give none
   always_comb begin
      judge_res = COL_NONE;
      if ((r_cnt_q > g_cnt_q) && (r_cnt_q > b_cnt_q) && (r_cnt_q >= MIN_C)) begin
         judge_res = COL_R;
      end else if ((g_cnt_q > r_cnt_q) && (g_cnt_q > b_cnt_q) && (g_cnt_q >= MIN_C)) begin
         judge_res = COL_G;
      end else if ((b_cnt_q > r_cnt_q) && (b_cnt_q > g_cnt_q) && (b_cnt_q >= MIN_C)) begin
         judge_res = COL_B;
      end else begin
         judge_res = COL_NONE;
      end
   end

   // Persistence tracking: repeat verdicts build confidence, a new verdict restarts at one
   always_comb begin
      cand_d = cand_q;
      pers_d = pers_q;
      if (judge_res == cand_q) begin
         if (pers_q == PER_C) begin
            pers_d = pers_q;
         end else begin
            pers_d = pers_q + PER_W'(1);
         end
      end else begin
         cand_d = judge_res;
         pers_d = PER_W'(1);
      end
   end

   // Measurement sequencer: filter select, settle, count window per channel, then judge
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= ST_SET_R;
         timer_q     <= TMR_ZERO;
         edge_cnt_q  <= CNT_ZERO;
         r_cnt_q     <= CNT_ZERO;
         g_cnt_q     <= CNT_ZERO;
         b_cnt_q     <= CNT_ZERO;
         s2_q        <= 1'b0;
         s3_q        <= 1'b0;
         meas_done_q <= 1'b0;
         valid_q     <= 3'b000;
         cand_q      <= COL_NONE;
         pers_q      <= PER_W'(0);
      end else begin
         meas_done_q <= 1'b0;
         case (state_q)
            ST_SET_R: begin
               s2_q    <= 1'b0;
               s3_q    <= 1'b0;
               timer_q <= SETTLE_LD;
               state_q <= ST_WAIT_R;
            end
            ST_SET_B: begin
               s2_q    <= 1'b0;
               s3_q    <= 1'b1;
               timer_q <= SETTLE_LD;
               state_q <= ST_WAIT_B;
            end
            ST_SET_G: begin
               s2_q    <= 1'b1;
               s3_q    <= 1'b1;
               timer_q <= SETTLE_LD;
               state_q <= ST_WAIT_G;
            end
            ST_WAIT_R, ST_WAIT_B, ST_WAIT_G: begin
               if (timer_q == TMR_ZERO) begin
                  edge_cnt_q <= CNT_ZERO;
                  timer_q    <= GATE_LD;
                  if (state_q == ST_WAIT_R) begin
                     state_q <= ST_GATE_R;
                  end else if (state_q == ST_WAIT_B) begin
                     state_q <= ST_GATE_B;
                  end else begin
                     state_q <= ST_GATE_G;
                  end
               end else begin
                  timer_q <= timer_q - TMR_W'(1);
               end
            end
            ST_GATE_R: begin
               edge_cnt_q <= edge_cnt_d;
               if (timer_q == TMR_ZERO) begin
                  r_cnt_q <= edge_cnt_d;
                  state_q <= ST_SET_B;
               end else begin
                  timer_q <= timer_q - TMR_W'(1);
               end
            end
            ST_GATE_B: begin
               edge_cnt_q <= edge_cnt_d;
               if (timer_q == TMR_ZERO) begin
                  b_cnt_q <= edge_cnt_d;
                  state_q <= ST_SET_G;
               end else begin
                  timer_q <= timer_q - TMR_W'(1);
               end
            end
            ST_GATE_G: begin
               edge_cnt_q <= edge_cnt_d;
               if (timer_q == TMR_ZERO) begin
                  g_cnt_q <= edge_cnt_d;
                  state_q <= ST_JUDGE;
               end else begin
                  timer_q <= timer_q - TMR_W'(1);
               end
            end
            ST_JUDGE: begin
               meas_done_q <= 1'b1;
               cand_q      <= cand_d;
               pers_q      <= pers_d;
               if (pers_d == PER_C) begin
                  valid_q <= color_onehot(cand_d);
               end else begin
                  valid_q <= valid_q;
               end
               state_q <= ST_SET_R;
            end
            default: begin
               state_q <= ST_SET_R;
            end
         endcase
      end
   end

   assign bus.s2        = s2_q;
   assign bus.s3        = s3_q;
   assign bus.r_cnt     = r_cnt_q;
   assign bus.g_cnt     = g_cnt_q;
   assign bus.b_cnt     = b_cnt_q;
   assign bus.meas_done = meas_done_q;
   assign bus.r_valid   = valid_q[2];
   assign bus.g_valid   = valid_q[1];
   assign bus.b_valid   = valid_q[0];

endmodule

// File: tb/tb_tcs3200_color_judge.sv
// Directed bench for tcs3200_color_judge. Two instances share one sensor model
// and one reset: "dut" with PERSIST=3 and "dut_p1" with PERSIST=1. Timing is
// scaled down (SETTLE=10, GATE=640, CNT_W=8, MIN_CNT=20) so a round is 1954
// clocks. The sensor toggles every hp clocks on the selected filter, so a
// window of 640 clocks holds exactly 640/(2*hp) rising edges.
module tb_tcs3200_color_judge;

   localparam int SETTLE = 10;
   localparam int GATE   = 640;
   localparam int CW     = 8;
   localparam int MINC   = 20;
   localparam int ROUND  = 3 * (1 + SETTLE + GATE) + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sensor = 1'b0;

   int errors = 0;
   int checks = 0;

   // per-channel half period in clocks (0 = held low)
   int hp_r = 2;
   int hp_g = 5;
   int hp_b = 10;
   bit burst_on_b = 1'b0;

   int gen_h;
   logic [1:0] gen_ch;
   logic [1:0] last_ch = 2'b00;
   int last_hp = 0;
   int ph = 0;
   int burst_left = 0;

   always #5 clk = ~clk;

   tcs3200_color_judge_if #(.CNT_W(CW)) bus3 ();
   tcs3200_color_judge_if #(.CNT_W(CW)) bus1 ();

   assign bus3.sensor_out = sensor;
   assign bus1.sensor_out = sensor;

   tcs3200_color_judge #(
      .SETTLE_CYC(SETTLE), .GATE_CYC(GATE), .CNT_W(CW), .MIN_CNT(MINC), .PERSIST(3)
   ) dut (
      .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus3.slave)
   );

   tcs3200_color_judge #(
      .SETTLE_CYC(SETTLE), .GATE_CYC(GATE), .CNT_W(CW), .MIN_CNT(MINC), .PERSIST(1)
   ) dut_p1 (
      .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus1.slave)
   );

   // selected filter and its half period
   always_comb begin
      gen_ch = {bus3.s2, bus3.s3};
      if (gen_ch == 2'b01) gen_h = hp_b;
      else if (gen_ch == 2'b11) gen_h = hp_g;
      else gen_h = hp_r;
   end

   // sensor model: restart phase on any filter/rate change, optional burst at the start of blue
   always @(negedge clk) begin
      if ((gen_ch != last_ch) || (gen_h != last_hp)) begin
         last_ch <= gen_ch;
         last_hp <= gen_h;
         ph      <= 0;
         if (gen_ch == 2'b01 && burst_on_b) burst_left <= 6;
      end else if (burst_left > 0) begin
         sensor     <= ~sensor;
         burst_left <= burst_left - 1;
      end else if (gen_h == 0) begin
         sensor <= 1'b0;
      end else if (ph >= gen_h - 1) begin
         sensor <= ~sensor;
         ph     <= 0;
      end else begin
         ph <= ph + 1;
      end
   end

   task automatic set_hp(input int r, input int g, input int b);
      hp_r = r;
      hp_g = g;
      hp_b = b;
   endtask

   // waits for meas_done (bounded) and watches both instances for multi-hot valids
   task automatic wait_done(output int n);
      logic bad;
      logic [2:0] v3;
      logic [2:0] v1;
      bad = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         v3 = {bus3.r_valid, bus3.g_valid, bus3.b_valid};
         v1 = {bus1.r_valid, bus1.g_valid, bus1.b_valid};
         if (((v3 & (v3 - 3'd1)) != 3'd0) || ((v1 & (v1 - 3'd1)) != 3'd0)) bad = 1'b1;
      end while (bus3.meas_done !== 1'b1 && n < ROUND + 50);
      checks++;
      if (bus3.meas_done !== 1'b1) begin
         errors++;
         $display("FAIL wait_done: meas_done=%b after %0d cycles, required 1", bus3.meas_done, n);
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL onehot: more than one valid high during round, required at most one");
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_hp(2, 5, 10);
      repeat (3) @(negedge clk);
      checks++;
      if ({bus3.s2, bus3.s3} !== 2'b00) begin
         errors++; $display("FAIL reset_s2s3: got %b required 00", {bus3.s2, bus3.s3});
      end
      checks++;
      if ({bus3.r_cnt, bus3.g_cnt, bus3.b_cnt} !== 24'd0) begin
         errors++; $display("FAIL reset_cnt: got %h required 000000", {bus3.r_cnt, bus3.g_cnt, bus3.b_cnt});
      end
      checks++;
      if (bus3.meas_done !== 1'b0) begin
         errors++; $display("FAIL reset_done: got %b required 0", bus3.meas_done);
      end
      checks++;
      if ({bus3.r_valid, bus3.g_valid, bus3.b_valid, bus1.r_valid, bus1.g_valid, bus1.b_valid} !== 6'b0) begin
         errors++; $display("FAIL reset_valid: got %b%b%b/%b%b%b required 000/000",
            bus3.r_valid, bus3.g_valid, bus3.b_valid, bus1.r_valid, bus1.g_valid, bus1.b_valid);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_red();
      int n;
      wait_done(n);
      checks++;
      if (n != ROUND) begin
         errors++; $display("FAIL red_round_len: got %0d required %0d", n, ROUND);
      end
      checks++;
      if (bus3.r_cnt !== 8'd160 || bus3.g_cnt !== 8'd64 || bus3.b_cnt !== 8'd32) begin
         errors++; $display("FAIL red_counts: got r=%0d g=%0d b=%0d required 160/64/32",
            bus3.r_cnt, bus3.g_cnt, bus3.b_cnt);
      end
      checks++;
      if (bus1.r_cnt !== 8'd160) begin
         errors++; $display("FAIL red_p1_rcnt: got %0d required 160", bus1.r_cnt);
      end
      checks++;
      if ({bus3.r_valid, bus3.g_valid, bus3.b_valid} !== 3'b000) begin
         errors++; $display("FAIL red_round1_valid: got %b%b%b required 000", bus3.r_valid, bus3.g_valid, bus3.b_valid);
      end
      checks++;
      if ({bus1.r_valid, bus1.g_valid, bus1.b_valid} !== 3'b100) begin
         errors++; $display("FAIL red_p1_round1: got %b%b%b required 100", bus1.r_valid, bus1.g_valid, bus1.b_valid);
      end
      @(negedge clk);
      checks++;
      if (bus3.meas_done !== 1'b0) begin
         errors++; $display("FAIL red_done_pulse: got %b one cycle later required 0", bus3.meas_done);
      end
      wait_done(n);
      checks++;
      if ({bus3.r_valid, bus3.g_valid, bus3.b_valid} !== 3'b000) begin
         errors++; $display("FAIL red_round2_valid: got %b%b%b required 000", bus3.r_valid, bus3.g_valid, bus3.b_valid);
      end
      wait_done(n);
      checks++;
      if ({bus3.r_valid, bus3.g_valid, bus3.b_valid} !== 3'b100) begin
         errors++; $display("FAIL red_round3_valid: got %b%b%b required 100", bus3.r_valid, bus3.g_valid, bus3.b_valid);
      end
   endtask

   task automatic test_change();
      int n;
      logic [2:0] exp_v [3];
      exp_v[0] = 3'b100; exp_v[1] = 3'b100; exp_v[2] = 3'b010;
      set_hp(10, 2, 10);
      for (int i = 0; i < 3; i++) begin
         wait_done(n);
         checks++;
         if ({bus3.r_valid, bus3.g_valid, bus3.b_valid} !== exp_v[i]) begin
            errors++; $display("FAIL change_round%0d: got %b%b%b required %b",
               i + 1, bus3.r_valid, bus3.g_valid, bus3.b_valid, exp_v[i]);
         end
      end
      checks++;
      if (bus3.g_cnt !== 8'd160 || bus3.r_cnt !== 8'd32 || bus3.b_cnt !== 8'd32) begin
         errors++; $display("FAIL change_counts: got r=%0d g=%0d b=%0d required 32/160/32",
            bus3.r_cnt, bus3.g_cnt, bus3.b_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      repeat (1 + SETTLE + GATE + 1 + SETTLE + 300) @(negedge clk);
      checks++;
      if ({bus3.s2, bus3.s3} !== 2'b01) begin
         errors++; $display("FAIL mid_gate_b_s2s3: got %b required 01", {bus3.s2, bus3.s3});
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus3.r_valid, bus3.g_valid, bus3.b_valid, bus1.r_valid, bus1.g_valid, bus1.b_valid} !== 6'b0) begin
         errors++; $display("FAIL mid_async_valid: got %b%b%b/%b%b%b required 000/000",
            bus3.r_valid, bus3.g_valid, bus3.b_valid, bus1.r_valid, bus1.g_valid, bus1.b_valid);
      end
      checks++;
      if ({bus3.s2, bus3.s3, bus3.meas_done} !== 3'b000 || bus3.g_cnt !== 8'd0) begin
         errors++; $display("FAIL mid_async_state: got s2s3done=%b%b%b g_cnt=%0d required 000 0",
            bus3.s2, bus3.s3, bus3.meas_done, bus3.g_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      wait_done(n);
      checks++;
      if (n != ROUND) begin
         errors++; $display("FAIL mid_restart_len: got %0d required %0d", n, ROUND);
      end
      checks++;
      if (bus3.g_cnt !== 8'd160 || {bus3.r_valid, bus3.g_valid, bus3.b_valid} !== 3'b000) begin
         errors++; $display("FAIL mid_round1: got g_cnt=%0d valid=%b%b%b required 160 000",
            bus3.g_cnt, bus3.r_valid, bus3.g_valid, bus3.b_valid);
      end
      checks++;
      if ({bus1.r_valid, bus1.g_valid, bus1.b_valid} !== 3'b010) begin
         errors++; $display("FAIL mid_p1_round1: got %b%b%b required 010", bus1.r_valid, bus1.g_valid, bus1.b_valid);
      end
      wait_done(n);
      checks++;
      if ({bus3.r_valid, bus3.g_valid, bus3.b_valid} !== 3'b000) begin
         errors++; $display("FAIL mid_round2: got %b%b%b required 000", bus3.r_valid, bus3.g_valid, bus3.b_valid);
      end
      wait_done(n);
      checks++;
      if ({bus3.r_valid, bus3.g_valid, bus3.b_valid} !== 3'b010) begin
         errors++; $display("FAIL mid_round3: got %b%b%b required 010", bus3.r_valid, bus3.g_valid, bus3.b_valid);
      end
   endtask

   task automatic test_tie_and_min();
      int n;
      // tie 80/80/80 -> none after three rounds (green held meanwhile)
      set_hp(4, 4, 4);
      wait_done(n);
      checks++;
      if (bus3.r_cnt !== 8'd80 || bus3.g_cnt !== 8'd80 || bus3.b_cnt !== 8'd80 ||
          {bus3.r_valid, bus3.g_valid, bus3.b_valid} !== 3'b010) begin
         errors++; $display("FAIL tie_round1: got r=%0d g=%0d b=%0d valid=%b%b%b required 80/80/80 010",
            bus3.r_cnt, bus3.g_cnt, bus3.b_cnt, bus3.r_valid, bus3.g_valid, bus3.b_valid);
      end
      checks++;
      if ({bus1.r_valid, bus1.g_valid, bus1.b_valid} !== 3'b000) begin
         errors++; $display("FAIL tie_p1: got %b%b%b required 000", bus1.r_valid, bus1.g_valid, bus1.b_valid);
      end
      wait_done(n);
      wait_done(n);
      checks++;
      if ({bus3.r_valid, bus3.g_valid, bus3.b_valid} !== 3'b000) begin
         errors++; $display("FAIL tie_round3: got %b%b%b required 000", bus3.r_valid, bus3.g_valid, bus3.b_valid);
      end
      // winner exactly at MIN_CNT: 20 vs 16/16 -> red
      set_hp(16, 20, 20);
      wait_done(n);
      checks++;
      if (bus3.r_cnt !== 8'd20 || bus3.g_cnt !== 8'd16) begin
         errors++; $display("FAIL min_eq_counts: got r=%0d g=%0d required 20/16", bus3.r_cnt, bus3.g_cnt);
      end
      wait_done(n);
      wait_done(n);
      checks++;
      if ({bus3.r_valid, bus3.g_valid, bus3.b_valid} !== 3'b100) begin
         errors++; $display("FAIL min_eq_valid: got %b%b%b required 100", bus3.r_valid, bus3.g_valid, bus3.b_valid);
      end
      // clear maximum but below MIN_CNT: 16/0/0 -> none
      set_hp(20, 0, 0);
      wait_done(n);
      checks++;
      if (bus3.r_cnt !== 8'd16 || bus3.g_cnt !== 8'd0 || bus3.b_cnt !== 8'd0) begin
         errors++; $display("FAIL min_lo_counts: got r=%0d g=%0d b=%0d required 16/0/0",
            bus3.r_cnt, bus3.g_cnt, bus3.b_cnt);
      end
      wait_done(n);
      wait_done(n);
      checks++;
      if ({bus3.r_valid, bus3.g_valid, bus3.b_valid} !== 3'b000) begin
         errors++; $display("FAIL min_lo_valid: got %b%b%b required 000", bus3.r_valid, bus3.g_valid, bus3.b_valid);
      end
   endtask

   task automatic test_sat_wait();
      int n;
      logic [1:0] prev;
      logic [1:0] seq [$];
      set_hp(1, 5, 0);
      burst_on_b = 1'b1;
      prev = {bus3.s2, bus3.s3};
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if ({bus3.s2, bus3.s3} != prev) seq.push_back({bus3.s2, bus3.s3});
         prev = {bus3.s2, bus3.s3};
      end while (bus3.meas_done !== 1'b1 && n < ROUND + 50);
      burst_on_b = 1'b0;
      checks++;
      if (bus3.meas_done !== 1'b1) begin
         errors++; $display("FAIL sat_timeout: meas_done=%b after %0d cycles, required 1", bus3.meas_done, n);
      end
      checks++;
      if (seq.size() != 3) begin
         errors++; $display("FAIL s2s3_seq_len: got %0d changes required 3", seq.size());
      end else if (seq[0] !== 2'b00 || seq[1] !== 2'b01 || seq[2] !== 2'b11) begin
         errors++; $display("FAIL s2s3_seq: got %b,%b,%b required 00,01,11", seq[0], seq[1], seq[2]);
      end
      checks++;
      if (bus3.r_cnt !== 8'd255) begin
         errors++; $display("FAIL sat_rcnt: got %0d required 255", bus3.r_cnt);
      end
      checks++;
      if (bus3.b_cnt !== 8'd0) begin
         errors++; $display("FAIL wait_edges_bcnt: got %0d required 0", bus3.b_cnt);
      end
      checks++;
      if (bus3.g_cnt !== 8'd64) begin
         errors++; $display("FAIL sat_gcnt: got %0d required 64", bus3.g_cnt);
      end
      checks++;
      if ({bus1.r_valid, bus1.g_valid, bus1.b_valid} !== 3'b100 ||
          {bus3.r_valid, bus3.g_valid, bus3.b_valid} !== 3'b000) begin
         errors++; $display("FAIL sat_valid: got p1=%b%b%b p3=%b%b%b required 100 000",
            bus1.r_valid, bus1.g_valid, bus1.b_valid, bus3.r_valid, bus3.g_valid, bus3.b_valid);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) set_hp(10, 5, 2);
         else set_hp(2, 5, 10);
         wait_done(n);
         checks++;
         if ({bus1.r_valid, bus1.g_valid, bus1.b_valid} !== ((i % 2 == 0) ? 3'b001 : 3'b100)) begin
            errors++; $display("FAIL alt_p1_round%0d: got %b%b%b required %b", i + 1,
               bus1.r_valid, bus1.g_valid, bus1.b_valid, (i % 2 == 0) ? 3'b001 : 3'b100);
         end
         checks++;
         if ({bus3.r_valid, bus3.g_valid, bus3.b_valid} !== 3'b000) begin
            errors++; $display("FAIL alt_p3_round%0d: got %b%b%b required 000", i + 1,
               bus3.r_valid, bus3.g_valid, bus3.b_valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_red();
      test_change();
      test_reset_mid();
      test_tie_and_min();
      test_sat_wait();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
